avmm_sdram_write_wrapper: RTL and testbench

Avalon-MM burst write master that turns a simple streaming write request into SDRAM bursts. It is the write-direction counterpart of avmm_sdram_read_wrapper and sits between NPU result writeback logic and the SDRAM controller's Avalon-MM slave port. A request of arbitrary length is split into bursts of at most MAX_BURST beats. Data enters through a valid/ready stream and is presented on the Avalon bus with waitrequest backpressure.

---
 rtl/avmm_sdram_write_wrapper.sv | 147 ++++++++++++++
 tb/tb_avmm_sdram_write_wrapper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_sdram_write_wrapper.sv
// Avalon-MM burst write master: splits a streamed write request of arbitrary
// length into SDRAM bursts of at most MAX_BURST beats, honouring waitrequest.
module avmm_sdram_write_wrapper #(
    parameter int SDRAM_DATA_W = 128,
    parameter int MAX_BURST    = 64,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               address,
    output logic [10:0]               burstcount,
    output logic [SDRAM_DATA_W-1:0]   writedata,
    output logic [SDRAM_DATA_W/8-1:0] byteenable,
    output logic                      write,
    input  logic                      waitrequest,
    input  logic [31:0]               write_addr,
    input  logic [CNT_W-1:0]          write_cnt,
    input  logic                      write_start,
    input  logic [SDRAM_DATA_W-1:0]   write_data,
    input  logic                      write_valid,
    output logic                      write_ready,
    output logic                      write_done,
    output logic                      write_busy
);

    localparam int                 BYTES       = SDRAM_DATA_W / 8;
    localparam logic [31:0]        BYTES_C     = 32'(BYTES);
    localparam logic [CNT_W-1:0]   MAX_BURST_C = CNT_W'(MAX_BURST);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [31:0]             cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [31:0]             address_q, address_d;
    logic [10:0]             burstcount_q, burstcount_d;
    logic [SDRAM_DATA_W-1:0] writedata_q, writedata_d;
    logic                    write_q, write_d;
    logic [10:0]             loaded_q, loaded_d;
    logic [10:0]             accepted_q, accepted_d;
    logic                    done_q, done_d;

    logic [10:0]             blen_next;
    logic                    beat_acc;
    logic                    load;
    logic                    last_beat;

    // burstcount_q doubles as the current burst length while in BURST
    assign blen_next   = (remaining_q > MAX_BURST_C) ? 11'(MAX_BURST) : 11'(remaining_q);
    assign beat_acc    = write_q && !waitrequest;
    assign write_ready = (state_q == ST_BURST) && (loaded_q < burstcount_q)
                         && (!write_q || !waitrequest);
    assign load        = write_valid && write_ready;
    assign last_beat   = beat_acc && ((accepted_q + 11'd1) == burstcount_q);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        address_d    = address_q;
        burstcount_d = burstcount_q;
        writedata_d  = writedata_q;
        write_d      = write_q;
        loaded_d     = loaded_q;
        accepted_d   = accepted_q;
        done_d       = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (write_start) begin
                    cur_addr_d  = write_addr;
                    remaining_d = write_cnt;
                    state_d     = (write_cnt == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                address_d    = cur_addr_q;
                burstcount_d = blen_next;
                loaded_d     = '0;
                accepted_d   = '0;
                state_d      = ST_BURST;
            end
            ST_BURST: begin
                // A stalled beat keeps write/writedata frozen because load needs !waitrequest
                if (load) begin
                    writedata_d = write_data;
                    write_d     = 1'b1;
                    loaded_d    = loaded_q + 11'd1;
                end else if (beat_acc) begin
                    write_d = 1'b0;
                end
                if (beat_acc) begin
                    accepted_d = accepted_q + 11'd1;
                end
                if (last_beat) begin
                    remaining_d = remaining_q - CNT_W'(burstcount_q);
                    cur_addr_d  = cur_addr_q + (32'(burstcount_q) * BYTES_C);
                    state_d     = (remaining_q == CNT_W'(burstcount_q)) ? ST_DONE : ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            address_q    <= '0;
            burstcount_q <= '0;
            writedata_q  <= '0;
            write_q      <= 1'b0;
            loaded_q     <= '0;
            accepted_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            address_q    <= address_d;
            burstcount_q <= burstcount_d;
            writedata_q  <= writedata_d;
            write_q      <= write_d;
            loaded_q     <= loaded_d;
            accepted_q   <= accepted_d;
            done_q       <= done_d;
        end
    end

    assign address    = address_q;
    assign burstcount = burstcount_q;
    assign writedata  = writedata_q;
    assign byteenable = '1;
    assign write      = write_q;
    assign write_done = done_q;
    assign write_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avmm_sdram_write_wrapper.sv
// Directed bench for avmm_sdram_write_wrapper with a slave BFM memory and a
// request-level model of the expected bus beats.
module tb_avmm_sdram_write_wrapper;

    localparam int DW    = 128;
    localparam int MAXB  = 64;
    localparam int BYTES = DW / 8;

    logic            clk;
    logic            rst;
    logic [31:0]     address;
    logic [10:0]     burstcount;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            write;
    logic            waitrequest;
    logic [31:0]     write_addr;
    logic [31:0]     write_cnt;
    logic            write_start;
    logic [DW-1:0]   write_data;
    logic            write_valid;
    logic            write_ready;
    logic            write_done;
    logic            write_busy;

    avmm_sdram_write_wrapper #(
        .SDRAM_DATA_W(DW),
        .MAX_BURST   (MAXB),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .burstcount (burstcount),
        .writedata  (writedata),
        .byteenable (byteenable),
        .write      (write),
        .waitrequest(waitrequest),
        .write_addr (write_addr),
        .write_cnt  (write_cnt),
        .write_start(write_start),
        .write_data (write_data),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .write_done (write_done),
        .write_busy (write_busy)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [10:0]   bc;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [31:0]   act_addr[$];
    logic [10:0]   act_bc[$];
    logic [DW-1:0] mem [logic [31:0]];

    int vec, fail, cyc;
    int wr_mode, src_mode, src_idx;
    logic [31:0] src_base;
    int acc_cnt, done_cnt, start_cyc, done_cyc, last_acc_cyc, bfm_beat, cur_cnt;
    bit saw_write, gap_seen, stall_prev;
    logic [171:0] stall_snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] beat_data(input logic [31:0] base, input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {base, kk, ~base, base ^ (kk * 32'h9E37_79B9)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source and slave drivers: change inputs just after the active edge
    initial begin
        waitrequest = 1'b0;
        write_valid = 1'b0;
        write_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            waitrequest = (wr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (src_mode)
                0:       write_valid = 1'b1;
                1:       write_valid = cyc[0];
                default: write_valid = 1'b0;
            endcase
            write_data = beat_data(src_base, src_idx);
        end
    end

    // Monitor: BFM memory, stall-hold checks and beat-by-beat model compare
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                bfm_beat   = 0;
            end else begin
                if (stall_prev)
                    chk("stall_hold", 256'({write, writedata, address, burstcount}), 256'(stall_snap));
                stall_prev = write && waitrequest;
                stall_snap = {write, writedata, address, burstcount};
                if (write && !waitrequest) begin
                    act_addr.push_back(address);
                    act_bc.push_back(burstcount);
                    mem[address + 32'(bfm_beat * BYTES)] = writedata;
                    bfm_beat++;
                    if (bfm_beat >= int'(burstcount)) bfm_beat = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 256'(acc_cnt + 1), 256'(cur_cnt));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 256'(writedata), 256'(e.data));
                        chk("beat_address", 256'(address), 256'(e.addr));
                        chk("beat_burstcount", 256'(burstcount), 256'(e.bc));
                        chk("byteenable", 256'(byteenable), 256'(16'hFFFF));
                    end
                    last_acc_cyc = cyc;
                    acc_cnt++;
                end
                if (write) saw_write = 1'b1;
                if (acc_cnt > 0 && acc_cnt < cur_cnt && write_busy && !write) gap_seen = 1'b1;
                if (write_valid && write_ready) src_idx++;
                if (write_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (write_start && !write_busy) start_cyc = cyc;
            end
        end
    end

    task automatic setup_run(input logic [31:0] a, input int n, input logic [31:0] base,
                             input int wm, input int sm);
        beat_t e;
        int    j, left;
        @(negedge clk);
        #1;
        wr_mode   = wm;
        src_mode  = sm;
        src_base  = base;
        src_idx   = 0;
        done_cnt  = 0;
        acc_cnt   = 0;
        saw_write = 1'b0;
        gap_seen  = 1'b0;
        cur_cnt   = n;
        mem.delete();
        act_addr.delete();
        act_bc.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            j      = k / MAXB;
            left   = n - j * MAXB;
            e.addr = a + 32'(j * MAXB * BYTES);
            e.bc   = 11'((left > MAXB) ? MAXB : left);
            e.data = beat_data(base, k);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        write_addr  = a;
        write_cnt   = 32'(n);
        write_start = 1'b1;
        @(posedge clk);
        #2;
        write_start = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [31:0] a, input int n,
                           input logic [31:0] base, input int wm, input int sm,
                           input bit spurious);
        int t;
        int bad;
        setup_run(a, n, base, wm, sm);
        if (spurious) begin
            repeat (4) @(posedge clk);
            #2;
            write_addr  = 32'h5000_0000;
            write_cnt   = 32'd7;
            write_start = 1'b1;
            @(posedge clk);
            #2;
            write_start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_done_seen"}, 256'(done_cnt != 0), 256'(1));
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_done_once"}, 256'(done_cnt), 256'(1));
        chk({tag, "_beats"}, 256'(acc_cnt), 256'(n));
        chk({tag, "_model_drained"}, 256'(exp_q.size()), 256'(0));
        chk({tag, "_busy_after"}, 256'(write_busy), 256'(0));
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (!mem.exists(a + 32'(k * BYTES))) bad++;
            else if (mem[a + 32'(k * BYTES)] !== beat_data(base, k)) bad++;
        end
        chk({tag, "_readback_bad_beats"}, 256'(bad), 256'(0));
        exp_q.delete();
        src_mode = 2;
        wr_mode  = 0;
    endtask

    initial begin
        int t;
        vec = 0; fail = 0; cyc = 0;
        wr_mode = 0; src_mode = 2; src_idx = 0; src_base = '0;
        acc_cnt = 0; done_cnt = 0; cur_cnt = 0; bfm_beat = 0;
        start_cyc = 0; done_cyc = 0; last_acc_cyc = 0;
        saw_write = 1'b0; gap_seen = 1'b0; stall_prev = 1'b0; stall_snap = '0;
        rst = 1'b1;
        write_start = 1'b0;
        write_addr  = '0;
        write_cnt   = '0;

        repeat (2) @(negedge clk);
        chk("rst_address", 256'(address), 256'(0));
        chk("rst_burstcount", 256'(burstcount), 256'(0));
        chk("rst_writedata", 256'(writedata), 256'(0));
        chk("rst_byteenable", 256'(byteenable), 256'(16'hFFFF));
        chk("rst_write", 256'(write), 256'(0));
        chk("rst_write_ready", 256'(write_ready), 256'(0));
        chk("rst_write_done", 256'(write_done), 256'(0));
        chk("rst_write_busy", 256'(write_busy), 256'(0));
        #1;
        rst = 1'b0;

        // single short burst, full rate
        run_req("short", 32'h2000_0000, 11, 32'h1111_0000, 0, 0, 1'b0);
        chk("short_first_addr", 256'(act_addr[0]), 256'(32'h2000_0000));
        chk("short_first_bc", 256'(act_bc[0]), 256'(11));
        chk("short_done_latency", 256'(done_cyc - last_acc_cyc), 256'(2));

        // 150 beats split into 64 + 64 + 22
        run_req("split", 32'h2000_0000, 150, 32'h2222_0000, 0, 0, 1'b0);
        chk("split_total", 256'(act_addr.size()), 256'(150));
        chk("split_b0_addr", 256'(act_addr[0]), 256'(32'h2000_0000));
        chk("split_b0_bc", 256'(act_bc[0]), 256'(64));
        chk("split_b1_addr", 256'(act_addr[64]), 256'(32'h2000_0400));
        chk("split_b1_bc", 256'(act_bc[64]), 256'(64));
        chk("split_b2_addr", 256'(act_addr[128]), 256'(32'h2000_0800));
        chk("split_b2_bc", 256'(act_bc[128]), 256'(22));

        // random waitrequest backpressure
        run_req("stall", 32'h2000_3000, 11, 32'h3333_0000, 1, 0, 1'b0);

        // source gaps every other cycle
        run_req("gaps", 32'h2000_4000, 11, 32'h4444_0000, 0, 1, 1'b0);
        chk("gaps_write_dropped", 256'(gap_seen), 256'(1));

        // zero length request
        run_req("zero", 32'h2000_5000, 0, 32'h5555_0000, 0, 0, 1'b0);
        chk("zero_no_write", 256'(saw_write), 256'(0));
        chk("zero_done_latency", 256'(done_cyc - start_cyc), 256'(2));

        // a start while busy must be ignored
        run_req("busy_ign", 32'h2000_6000, 11, 32'h6666_0000, 0, 0, 1'b1);

        // reset in the middle of a burst
        setup_run(32'h2000_7000, 11, 32'h7777_0000, 0, 0);
        t = 0;
        while (acc_cnt < 5 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("midrst_reached_beat5", 256'(acc_cnt >= 5), 256'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_write", 256'(write), 256'(0));
        chk("midrst_write_ready", 256'(write_ready), 256'(0));
        chk("midrst_write_busy", 256'(write_busy), 256'(0));
        src_mode = 2;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        run_req("after_rst", 32'h2000_8000, 11, 32'h8888_0000, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
        $finish;
    end

endmodule
